// File: rtl/wrd_pkg.sv
// Shared types for the multi-bank write/read manager: per-bank state,
// write/read FSM states and the drop-counter width.
package wrd_pkg;

    localparam int unsigned DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_e;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_BUSY = 1'b1
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_BUSY = 1'b1
    } rd_state_e;

    // A bank holds a complete frame once it is FULL and until its read ends
    function automatic logic is_occupied(input bank_state_e s);
        return (s == FULL) || (s == READING);
    endfunction

endpackage

// File: rtl/mbwm_bank_table.sv
// Per-bank state table. Strobes from the write and read FSMs move
// individual banks between FREE, WRITING, FULL and READING; every bank
// updates independently, so strobes on different banks in one cycle all apply.
module mbwm_bank_table
    import wrd_pkg::*;
#(
    parameter  int unsigned NUM_BANKS = 4,
    localparam int unsigned BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_set_wr,
    input  logic [BANK_W-1:0]    i_wr_idx,
    input  logic                 i_set_full,
    input  logic [BANK_W-1:0]    i_full_idx,
    input  logic                 i_set_rd,
    input  logic [BANK_W-1:0]    i_rd_idx,
    input  logic                 i_set_free,
    input  logic [BANK_W-1:0]    i_free_idx,
    output logic [NUM_BANKS-1:0] o_free_c,
    output logic [NUM_BANKS-1:0] o_full_c,
    output logic [NUM_BANKS-1:0] o_bank_full
);

    bank_state_e r_state [NUM_BANKS];
    bank_state_e w_next  [NUM_BANKS];

    // Next state of each bank from the strobes addressed to it
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_next[b] = r_state[b];
            if (i_set_free && (i_free_idx == BANK_W'(b))) w_next[b] = FREE;
            if (i_set_full && (i_full_idx == BANK_W'(b))) w_next[b] = FULL;
            if (i_set_rd   && (i_rd_idx   == BANK_W'(b))) w_next[b] = READING;
            if (i_set_wr   && (i_wr_idx   == BANK_W'(b))) w_next[b] = WRITING;
        end
    end

    // State registers plus the registered occupancy vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_state[b] <= FREE;
            end
            o_bank_full <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_state[b]     <= w_next[b];
                o_bank_full[b] <= is_occupied(w_next[b]);
            end
        end
    end

    // FREE / FULL decode of the registered states for the FSM decisions
    always_comb begin
        o_free_c = '0;
        o_full_c = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            o_free_c[b] = (r_state[b] == FREE);
            o_full_c[b] = (r_state[b] == FULL);
        end
    end

endmodule

// File: rtl/multibank_wrd_manage.sv
// N-bank round-robin write/read manager for the transpose datapath.
// Frames are written into banks in order and read back in the same order;
// a frame start (or chained write) with no free bank is dropped and flagged.
// Optional: define MBWM_DROP_CNT_EN to add a saturating 16-bit drop_cnt port.
module multibank_wrd_manage
    import wrd_pkg::*;
#(
    parameter  int unsigned NUM_BANKS = 4,
    localparam int unsigned BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  data_in_valid,
    input  logic                  wr_finish,
    input  logic                  rd_finish,
    output logic                  wr_command,
    output logic [BANK_W-1:0]     wr_bank,
    output logic                  wr_active,
    output logic                  rd_command,
    output logic [BANK_W-1:0]     rd_bank,
    output logic                  rd_active,
    output logic [NUM_BANKS-1:0]  bank_full,
`ifdef MBWM_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    output logic                  frame_drop
);

    if (NUM_BANKS < 2) begin : g_bad_num_banks
        $error("multibank_wrd_manage: NUM_BANKS must be at least 2");
    end

    // Round-robin pointer advance, wrapping from NUM_BANKS-1 to 0
    function automatic logic [BANK_W-1:0] ptr_inc(input logic [BANK_W-1:0] p);
        return (p == BANK_W'(NUM_BANKS - 1)) ? '0 : p + BANK_W'(1);
    endfunction

    wr_state_e           r_wr_state;
    rd_state_e           r_rd_state;
    logic [BANK_W-1:0]   r_wr_ptr;
    logic [BANK_W-1:0]   r_rd_ptr;
    logic                r_wr_command;
    logic [BANK_W-1:0]   r_wr_bank;
    logic                r_wr_active;
    logic                r_rd_command;
    logic [BANK_W-1:0]   r_rd_bank;
    logic                r_rd_active;
    logic                r_frame_drop;

    logic [NUM_BANKS-1:0] w_free;
    logic [NUM_BANKS-1:0] w_full;
    logic [BANK_W-1:0]    w_wr_next;
    logic                 w_start_ok;
    logic                 w_start_drop;
    logic                 w_wr_done;
    logic                 w_chain_ok;
    logic                 w_chain_drop;
    logic                 w_set_wr;
    logic [BANK_W-1:0]    w_wr_idx;
    logic                 w_rd_go;
    logic                 w_rd_done;
    logic                 w_drop;

    // Grant/drop decisions, all taken from the registered bank states
    always_comb begin
        w_wr_next    = ptr_inc(r_wr_ptr);
        w_start_ok   = 1'b0;
        w_start_drop = 1'b0;
        w_chain_ok   = 1'b0;
        w_chain_drop = 1'b0;
        w_wr_done    = (r_wr_state == WR_BUSY) && wr_finish;
        if ((r_wr_state == WR_IDLE) && frame_start) begin
            if (w_free[r_wr_ptr]) w_start_ok   = 1'b1;
            else                  w_start_drop = 1'b1;
        end
        if (w_wr_done && data_in_valid) begin
            if (w_free[w_wr_next]) w_chain_ok   = 1'b1;
            else                   w_chain_drop = 1'b1;
        end
        w_set_wr  = w_start_ok || w_chain_ok;
        w_wr_idx  = w_chain_ok ? w_wr_next : r_wr_ptr;
        w_rd_go   = (r_rd_state == RD_IDLE) && w_full[r_rd_ptr];
        w_rd_done = (r_rd_state == RD_BUSY) && rd_finish;
        w_drop    = w_start_drop || w_chain_drop;
    end

    mbwm_bank_table #(
        .NUM_BANKS (NUM_BANKS)
    ) u_bank_table (
        .clk         (clk),
        .rst         (rst),
        .i_set_wr    (w_set_wr),
        .i_wr_idx    (w_wr_idx),
        .i_set_full  (w_wr_done),
        .i_full_idx  (r_wr_ptr),
        .i_set_rd    (w_rd_go),
        .i_rd_idx    (r_rd_ptr),
        .i_set_free  (w_rd_done),
        .i_free_idx  (r_rd_ptr),
        .o_free_c    (w_free),
        .o_full_c    (w_full),
        .o_bank_full (bank_full)
    );

    // Write FSM: frame acceptance, chaining and drop reporting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state   <= WR_IDLE;
            r_wr_ptr     <= '0;
            r_wr_command <= 1'b0;
            r_wr_bank    <= '0;
            r_wr_active  <= 1'b0;
            r_frame_drop <= 1'b0;
        end else begin
            r_wr_command <= w_set_wr;
            r_frame_drop <= w_drop;
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_start_ok) begin
                        r_wr_state  <= WR_BUSY;
                        r_wr_bank   <= r_wr_ptr;
                        r_wr_active <= 1'b1;
                    end
                end
                WR_BUSY: begin
                    if (w_wr_done) begin
                        r_wr_ptr <= w_wr_next;
                        if (w_chain_ok) begin
                            r_wr_bank <= w_wr_next;
                        end else begin
                            r_wr_state  <= WR_IDLE;
                            r_wr_active <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_wr_state  <= WR_IDLE;
                    r_wr_active <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: start reading the oldest full bank, release it on rd_finish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state   <= RD_IDLE;
            r_rd_ptr     <= '0;
            r_rd_command <= 1'b0;
            r_rd_bank    <= '0;
            r_rd_active  <= 1'b0;
        end else begin
            r_rd_command <= w_rd_go;
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_rd_go) begin
                        r_rd_state  <= RD_BUSY;
                        r_rd_bank   <= r_rd_ptr;
                        r_rd_active <= 1'b1;
                    end
                end
                RD_BUSY: begin
                    if (w_rd_done) begin
                        r_rd_state  <= RD_IDLE;
                        r_rd_ptr    <= ptr_inc(r_rd_ptr);
                        r_rd_active <= 1'b0;
                    end
                end
                default: begin
                    r_rd_state  <= RD_IDLE;
                    r_rd_active <= 1'b0;
                end
            endcase
        end
    end

    assign wr_command = r_wr_command;
    assign wr_bank    = r_wr_bank;
    assign wr_active  = r_wr_active;
    assign rd_command = r_rd_command;
    assign rd_bank    = r_rd_bank;
    assign rd_active  = r_rd_active;
    assign frame_drop = r_frame_drop;

`ifdef MBWM_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // Saturating count of dropped frames, moving with the frame_drop pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_multibank_wrd_manage.sv
// Directed bench for multibank_wrd_manage (NUM_BANKS=3) with a cycle-level
// behavioural model compared every cycle plus hand-computed literal checks.
module tb_multibank_wrd_manage;

    localparam int NB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          frame_start;
    logic          data_in_valid;
    logic          wr_finish;
    logic          rd_finish;
    logic          wr_command;
    logic [1:0]    wr_bank;
    logic          wr_active;
    logic          rd_command;
    logic [1:0]    rd_bank;
    logic          rd_active;
    logic [NB-1:0] bank_full;
    logic          frame_drop;
`ifdef MBWM_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    multibank_wrd_manage #(
        .NUM_BANKS (NB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .data_in_valid (data_in_valid),
        .wr_finish     (wr_finish),
        .rd_finish     (rd_finish),
        .wr_command    (wr_command),
        .wr_bank       (wr_bank),
        .wr_active     (wr_active),
        .rd_command    (rd_command),
        .rd_bank       (rd_bank),
        .rd_active     (rd_active),
        .bank_full     (bank_full),
`ifdef MBWM_DROP_CNT_EN
        .drop_cnt      (drop_cnt),
`endif
        .frame_drop    (frame_drop)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // bank states: 0 free, 1 writing, 2 full, 3 reading
    int m_st   [NB];
    int m_snap [NB];
    int m_wp, m_rp;
    bit m_wbusy, m_rbusy;
    bit e_wr_command, e_rd_command, e_frame_drop;
    int e_wr_bank, e_rd_bank, e_bank_full, e_drop_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) m_st[b] = 0;
            m_wp = 0; m_rp = 0; m_wbusy = 0; m_rbusy = 0;
            e_wr_command = 0; e_rd_command = 0; e_frame_drop = 0;
            e_wr_bank = 0; e_rd_bank = 0; e_bank_full = 0; e_drop_cnt = 0;
        end else begin
            for (int b = 0; b < NB; b++) m_snap[b] = m_st[b];
            e_wr_command = 0; e_rd_command = 0; e_frame_drop = 0;
            if (!m_wbusy) begin
                if (frame_start) begin
                    if (m_snap[m_wp] == 0) begin
                        m_st[m_wp] = 1; m_wbusy = 1; e_wr_command = 1; e_wr_bank = m_wp;
                    end else begin
                        e_frame_drop = 1;
                    end
                end
            end else if (wr_finish) begin
                m_st[m_wp] = 2;
                m_wp = (m_wp + 1) % NB;
                if (data_in_valid && m_snap[m_wp] == 0) begin
                    m_st[m_wp] = 1; e_wr_command = 1; e_wr_bank = m_wp;
                end else begin
                    m_wbusy = 0;
                    if (data_in_valid) e_frame_drop = 1;
                end
            end
            if (!m_rbusy) begin
                if (m_snap[m_rp] == 2) begin
                    m_st[m_rp] = 3; m_rbusy = 1; e_rd_command = 1; e_rd_bank = m_rp;
                end
            end else if (rd_finish) begin
                m_st[m_rp] = 0;
                m_rp = (m_rp + 1) % NB;
                m_rbusy = 0;
            end
            e_bank_full = 0;
            for (int b = 0; b < NB; b++)
                if (m_st[b] >= 2) e_bank_full = e_bank_full + (1 << b);
            if (e_frame_drop && e_drop_cnt < 65535) e_drop_cnt = e_drop_cnt + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("m_wr_command", 32'(wr_command), 32'(e_wr_command));
            chk("m_wr_active",  32'(wr_active),  32'(m_wbusy));
            if (m_wbusy) chk("m_wr_bank", 32'(wr_bank), e_wr_bank);
            chk("m_rd_command", 32'(rd_command), 32'(e_rd_command));
            chk("m_rd_active",  32'(rd_active),  32'(m_rbusy));
            if (m_rbusy) chk("m_rd_bank", 32'(rd_bank), e_rd_bank);
            chk("m_bank_full",  32'(bank_full),  e_bank_full);
            chk("m_frame_drop", 32'(frame_drop), 32'(e_frame_drop));
`ifdef MBWM_DROP_CNT_EN
            chk("m_drop_cnt",   32'(drop_cnt),   e_drop_cnt);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        frame_start   = 1'b0;
        data_in_valid = 1'b0;
        wr_finish     = 1'b0;
        rd_finish     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_command"}, 32'(wr_command), 0);
        chk({tag, "_wr_active"},  32'(wr_active),  0);
        chk({tag, "_wr_bank"},    32'(wr_bank),    0);
        chk({tag, "_rd_command"}, 32'(rd_command), 0);
        chk({tag, "_rd_active"},  32'(rd_active),  0);
        chk({tag, "_rd_bank"},    32'(rd_bank),    0);
        chk({tag, "_bank_full"},  32'(bank_full),  0);
        chk({tag, "_frame_drop"}, 32'(frame_drop), 0);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; data_in_valid = 1'b0;
        wr_finish = 1'b0; rd_finish = 1'b0;
        step(); step();
        chk_all_zero("reset");
        rst = 1'b0;
        step(); step();

        // single frame
        frame_start = 1'b1; step();
        chk("s1_wr_command", 32'(wr_command), 1);
        chk("s1_wr_bank",    32'(wr_bank),    0);
        chk("s1_wr_active",  32'(wr_active),  1);
        step();
        chk("s1_wr_cmd_pulse", 32'(wr_command), 0);
        repeat (4) step();
        wr_finish = 1'b1; step();
        chk("s1_bank_full",   32'(bank_full),  32'h1);
        chk("s1_wr_idle",     32'(wr_active),  0);
        chk("s1_rd_cmd_early",32'(rd_command), 0);
        step();
        chk("s1_rd_command",  32'(rd_command), 1);
        chk("s1_rd_bank",     32'(rd_bank),    0);
        step();
        chk("s1_rd_cmd_pulse",32'(rd_command), 0);
        rd_finish = 1'b1; step();
        chk("s1_freed",       32'(bank_full),  0);
        chk("s1_rd_idle",     32'(rd_active),  0);

        // chaining with wrap 0,1,2,0
        do_reset();
        frame_start = 1'b1; step();
        chk("s2_wr_bank0", 32'(wr_bank), 0);
        wr_finish = 1'b1; data_in_valid = 1'b1; step();
        chk("s2_chain1_cmd", 32'(wr_command), 1);
        chk("s2_wr_bank1",   32'(wr_bank),    1);
        wr_finish = 1'b1; data_in_valid = 1'b1; step();
        chk("s2_wr_bank2",   32'(wr_bank),    2);
        chk("s2_rd_bank0",   32'(rd_bank),    0);
        chk("s2_rd_cmd0",    32'(rd_command), 1);
        rd_finish = 1'b1; step();
        chk("s2_full_010",   32'(bank_full),  32'h2);
        wr_finish = 1'b1; data_in_valid = 1'b1; step();
        chk("s2_wrap_cmd",   32'(wr_command), 1);
        chk("s2_wrap_bank0", 32'(wr_bank),    0);
        chk("s2_rd_bank1",   32'(rd_bank),    1);
        rd_finish = 1'b1; step();
        step();
        chk("s2_rd_bank2",   32'(rd_bank),    2);

        // overflow with reads stalled
        do_reset();
        repeat (3) begin
            frame_start = 1'b1; step();
            step();
            wr_finish = 1'b1; step();
        end
        step();
        frame_start = 1'b1; step();
        chk("s3_drop",       32'(frame_drop), 1);
        chk("s3_no_wr_cmd",  32'(wr_command), 0);
        chk("s3_full_111",   32'(bank_full),  32'h7);
`ifdef MBWM_DROP_CNT_EN
        chk("s3_drop_cnt",   32'(drop_cnt),   1);
`endif
        step();
        chk("s3_drop_pulse", 32'(frame_drop), 0);

        // same-cycle free and start: dropped, retry accepted
        rd_finish = 1'b1; frame_start = 1'b1; step();
        chk("s4_drop",       32'(frame_drop), 1);
        chk("s4_no_wr_cmd",  32'(wr_command), 0);
        chk("s4_full_110",   32'(bank_full),  32'h6);
        frame_start = 1'b1; step();
        chk("s4_retry_cmd",  32'(wr_command), 1);
        chk("s4_retry_bank", 32'(wr_bank),    0);
        chk("s4_retry_nodrop", 32'(frame_drop), 0);
        // chained write into a busy bank is dropped
        wr_finish = 1'b1; data_in_valid = 1'b1; step();
        chk("s4_chain_drop", 32'(frame_drop), 1);
        chk("s4_chain_idle", 32'(wr_active),  0);
        chk("s4_full_111",   32'(bank_full),  32'h7);
`ifdef MBWM_DROP_CNT_EN
        chk("s4_drop_cnt",   32'(drop_cnt),   3);
`endif

        // simultaneous wr_finish (bank 1) and rd_finish (bank 0)
        do_reset();
        frame_start = 1'b1; step();
        wr_finish = 1'b1; data_in_valid = 1'b1; step();
        step();
        wr_finish = 1'b1; rd_finish = 1'b1; step();
        chk("s5_full_010",   32'(bank_full),  32'h2);
        step();
        chk("s5_rd_cmd",     32'(rd_command), 1);
        chk("s5_rd_bank1",   32'(rd_bank),    1);

        // reset while both FSMs are busy
        frame_start = 1'b1; step();
        chk("s6_wr_bank2",   32'(wr_bank),    2);
        chk("s6_both_busy",  32'(wr_active & rd_active), 1);
        #2; rst = 1'b1; #1;
        chk_all_zero("s6_async");
        step();
        rst = 1'b0;
        step();
        frame_start = 1'b1; step();
        chk("s6_post_cmd",   32'(wr_command), 1);
        chk("s6_post_bank0", 32'(wr_bank),    0);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
